// File: rtl/rx_pkg.sv
// Shared types and default sizing for the serial receiver control path.
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_CHK,
      RECEIVE,
      CHECK
   } rx_state_t;

   localparam int RX_MAX_DATA_BITS = 8;  // default rx_data buffer width
   localparam int RX_HALF_MIN      = 1;  // floor for the start-bit check length

endpackage

// File: rtl/rx_start_detector.sv
// Two-flop synchronizer for the raw serial line plus a falling-edge detector
// that flags the leading edge of a start bit.
module rx_start_detector (
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   output logic sync_serial,
   output logic start_edge
);

   logic meta;
   logic prev;

   // Synchronize the line and keep the previous synchronized sample; the line idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta        <= 1'b1;
         sync_serial <= 1'b1;
         prev        <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make the three flops shift in lock-step;
         // blocking ones would collapse the chain into a single stage.
         meta        <= serial_in;
         sync_serial <= meta;
         prev        <= sync_serial;
      end
   end

   assign start_edge = prev & ~sync_serial;

endmodule

// File: rtl/rx_control_unit.sv
// Receive-side control: validates the start bit, shifts data in LSB first on
// bit-timer strobes, checks the stop bit and reports status to the host.
module rx_control_unit
   import rx_pkg::*;
#(
   parameter int MAX_DATA_BITS = RX_MAX_DATA_BITS,
   parameter int HALF_MIN      = RX_HALF_MIN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     serial_in,
   input  logic [3:0]               data_size,
   input  logic [13:0]              bit_period,
   input  logic                     shift_strobe,
   input  logic                     packet_done,
   input  logic                     data_read,
   output logic                     enable_timer,
   output logic [MAX_DATA_BITS-1:0] rx_data,
   output logic                     data_ready,
   output logic                     overrun_error,
   output logic                     framing_error,
   output logic                     rx_busy
);

   localparam int CNT_W = $clog2(MAX_DATA_BITS + 2);
   localparam int CMP_W = (CNT_W > 4) ? CNT_W : 4;

   rx_state_t                state;
   rx_state_t                next_state;
   logic                     sync_serial;
   logic                     start_edge;
   logic [12:0]              half_cnt;
   logic [12:0]              half_load;
   logic [CNT_W-1:0]         bit_cnt;
   logic [CMP_W-1:0]         bit_cnt_ext;
   logic [CMP_W-1:0]         size_ext;
   logic [MAX_DATA_BITS-1:0] shift_reg;
   logic [MAX_DATA_BITS-1:0] aligned_data;
   logic                     stop_bit;

   rx_start_detector u_start_detector (
      .clk         (clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .sync_serial (sync_serial),
      .start_edge  (start_edge)
   );

   // Derived values: start-check length, counter comparison widths, right-aligned frame.
   always_comb begin
      half_load = 13'(bit_period >> 1);
      if (half_load < 13'(HALF_MIN)) begin
         half_load = 13'(HALF_MIN);
      end
      bit_cnt_ext  = CMP_W'(bit_cnt);
      size_ext     = CMP_W'(data_size);
      aligned_data = shift_reg >> (MAX_DATA_BITS - int'(data_size));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and timer-enable decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      next_state   = state;
      enable_timer = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               next_state = START_CHK;
            end
         end
         START_CHK: begin
            if (half_cnt <= 13'd1) begin
               next_state = sync_serial ? IDLE : RECEIVE;
            end
         end
         RECEIVE: begin
            enable_timer = 1'b1;
            if (packet_done) begin
               next_state = CHECK;
            end
         end
         CHECK: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign rx_busy = (state != IDLE);

   // Counters, shift register and host-side status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         half_cnt      <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         stop_bit      <= 1'b0;
         rx_data       <= '0;
         data_ready    <= 1'b0;
         overrun_error <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         // A host read clears the flags; a frame load later in this block overrides it.
         if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start_edge) begin
                  half_cnt      <= half_load;
                  framing_error <= 1'b0;
               end
            end
            START_CHK: begin
               half_cnt <= half_cnt - 13'd1;
               if (half_cnt <= 13'd1 && !sync_serial) begin
                  bit_cnt   <= '0;
                  shift_reg <= '0;
               end
            end
            RECEIVE: begin
               if (shift_strobe) begin
                  if (bit_cnt_ext < size_ext) begin
                     shift_reg <= {sync_serial, shift_reg[MAX_DATA_BITS-1:1]};
                     bit_cnt   <= bit_cnt + CNT_W'(1);
                  end else if (bit_cnt_ext == size_ext) begin
                     stop_bit <= sync_serial;
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            CHECK: begin
               if (stop_bit) begin
                  rx_data    <= aligned_data;
                  data_ready <= 1'b1;
                  if (data_ready && !data_read) begin
                     overrun_error <= 1'b1;
                  end
               end else begin
                  framing_error <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_control_unit.sv
// Bench for rx_control_unit: a bit-timer model feeds strobes, directed frames
// are driven on the serial line, and a monitor compares each frame's outcome
// against expectations queued by the stimulus.
module tb_rx_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic [3:0] data_size;
   logic [13:0] bit_period;
   logic       shift_strobe;
   logic       packet_done;
   logic       data_read;
   logic       enable_timer;
   logic [7:0] rx_data;
   logic       data_ready;
   logic       overrun_error;
   logic       framing_error;
   logic       rx_busy;

   typedef struct {
      logic [7:0] data;
      logic       ready;
      logic       overrun;
      logic       framing;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   idle_en = 0;

   rx_control_unit dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .data_size     (data_size),
      .bit_period    (bit_period),
      .shift_strobe  (shift_strobe),
      .packet_done   (packet_done),
      .data_read     (data_read),
      .enable_timer  (enable_timer),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .overrun_error (overrun_error),
      .framing_error (framing_error),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic r, input logic o, input logic f);
      exp_t e;
      e.data    = d;
      e.ready   = r;
      e.overrun = o;
      e.framing = f;
      return e;
   endfunction

   // Bit timer model: strobe every bit_period cycles while enabled; packet_done
   // rises with the (data_size+1)th strobe and holds until the enable drops.
   initial begin
      int tcnt;
      int scnt;
      tcnt = 0;
      scnt = 0;
      shift_strobe = 1'b0;
      packet_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (!enable_timer) begin
            tcnt = 0;
            scnt = 0;
            shift_strobe = 1'b0;
            packet_done  = 1'b0;
         end else if (tcnt == int'(bit_period) - 1) begin
            tcnt = 0;
            scnt++;
            shift_strobe = 1'b1;
            if (scnt == int'(data_size) + 1) packet_done = 1'b1;
         end else begin
            tcnt++;
            shift_strobe = 1'b0;
         end
      end
   end

   // Monitor: every return to IDLE outside reset ends one expected frame outcome.
   initial begin
      logic prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (enable_timer && !rx_busy) idle_en++;
         if (!rst && prev_busy && !rx_busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame_end", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e.data));
               check("data_ready", 32'(data_ready), 32'(e.ready));
               check("overrun_error", 32'(overrun_error), 32'(e.overrun));
               check("framing_error", 32'(framing_error), 32'(e.framing));
               check("idle_enable_timer", 32'(enable_timer), 32'd0);
            end
         end
         prev_busy = rx_busy;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_val);
      serial_in = 1'b0;
      repeat (bit_period) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         serial_in = data[i];
         repeat (bit_period) @(negedge clk);
      end
      serial_in = stop_val;
      repeat (bit_period) @(negedge clk);
      serial_in = 1'b1;
      repeat (2 * bit_period) @(negedge clk);
   endtask

   task automatic read_pulse(input string tag);
      data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
      check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
      check({tag, "_overrun"}, 32'(overrun_error), 32'd0);
   endtask

   initial begin
      int en_hi;
      int busy_seen;
      logic saw_en;
      rst        = 1'b1;
      serial_in  = 1'b1;
      data_read  = 1'b0;
      data_size  = 4'd8;
      bit_period = 14'd10;
      repeat (3) @(negedge clk);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      check("reset_data_ready", 32'(data_ready), 32'd0);
      check("reset_overrun", 32'(overrun_error), 32'd0);
      check("reset_framing", 32'(framing_error), 32'd0);
      check("reset_busy", 32'(rx_busy), 32'd0);
      check("reset_enable", 32'(enable_timer), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Good frame 0xA5.
      exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
      send_frame(8'hA5, 8, 1'b1);

      // Three-cycle low glitch: start check runs, then falls back to IDLE.
      exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
      en_hi = 0;
      busy_seen = 0;
      for (int i = 0; i < 25; i++) begin
         serial_in = (i < 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (enable_timer) en_hi++;
         if (rx_busy) busy_seen++;
      end
      check("glitch_enable_cycles", 32'(en_hi), 32'd0);
      check("glitch_busy_seen", 32'(busy_seen > 0), 32'd1);

      // Stop bit 0: framing error, buffer and data_ready untouched.
      exp_q.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b1));
      send_frame(8'h5A, 8, 1'b0);
      read_pulse("read1");
      check("read1_framing_kept", 32'(framing_error), 32'd1);

      // Two good frames without a read: overrun on the second.
      exp_q.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
      send_frame(8'h3C, 8, 1'b1);
      exp_q.push_back(mk(8'h81, 1'b1, 1'b1, 1'b0));
      send_frame(8'h81, 8, 1'b1);
      read_pulse("read2");

      // Five-bit frame, bits 1,0,1,1,0 LSB first.
      data_size = 4'd5;
      exp_q.push_back(mk(8'h0D, 1'b1, 1'b0, 1'b0));
      send_frame(8'h0D, 5, 1'b1);

      // Reset in the middle of RECEIVE.
      data_size = 4'd8;
      fork
         send_frame(8'hFF, 8, 1'b1);
         begin
            saw_en = 1'b0;
            for (int i = 0; i < 60 && !saw_en; i++) begin
               @(negedge clk);
               saw_en = enable_timer;
            end
            check("midreset_reached_receive", 32'(saw_en), 32'd1);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("midreset_busy", 32'(rx_busy), 32'd0);
            check("midreset_enable", 32'(enable_timer), 32'd0);
            check("midreset_rx_data", 32'(rx_data), 32'd0);
            check("midreset_data_ready", 32'(data_ready), 32'd0);
            check("midreset_overrun", 32'(overrun_error), 32'd0);
            check("midreset_framing", 32'(framing_error), 32'd0);
            @(negedge clk);
            rst = 1'b0;
         end
      join

      // Frame after the mid-frame reset.
      exp_q.push_back(mk(8'h96, 1'b1, 1'b0, 1'b0));
      send_frame(8'h96, 8, 1'b1);

      repeat (5) @(negedge clk);
      check("pending_expectations", 32'(exp_q.size()), 32'd0);
      check("enable_while_idle", 32'(idle_en), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
